// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FSM state type and Q-format helpers for the conv2d_mac engine.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC,
        DRAIN,
        WRITE,
        FINISH
    } state_t;

    // Address width for a memory of 'depth' words; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Floor-shift a wide accumulator by frac_bits, then clamp to the signed data_width range.
    function automatic logic signed [31:0] q_shift_sat(
        input logic signed [63:0] acc,
        input int                 frac_bits,
        input int                 data_width
    );
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        shifted = acc >>> frac_bits;
        max_v   = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (data_width - 1));
        if (shifted > max_v) begin
            return 32'(max_v);
        end
        if (shifted < min_v) begin
            return 32'(min_v);
        end
        return 32'(shifted);
    endfunction

endpackage

// File: rtl/mac_acc.sv
// mac_acc: multiply-accumulate datapath for one output pixel.
// The accumulator is loaded with the scaled bias, accumulates one product per
// cycle, and presents the floor-shifted, saturated result.
// Optional feature macro: CONV2D_RELU_EN (clamps negative results to zero).
module mac_acc
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 7,
    parameter int ACC_W      = 37
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         load_bias,
    input  logic signed [DATA_WIDTH-1:0] bias,
    input  logic                         acc_en,
    input  logic                         tap_zero,
    input  logic signed [DATA_WIDTH-1:0] feat,
    input  logic signed [DATA_WIDTH-1:0] wgt,
    output logic signed [DATA_WIDTH-1:0] result
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        acc_reg;
    logic signed [ACC_W-1:0]        acc_next;
    logic signed [31:0]             sat_val;

    // Product of the tap whose memory data is arriving now; padding taps contribute zero.
    always_comb begin
        prod = '0;
        if (!tap_zero) begin
            prod = (2*DATA_WIDTH)'(feat) * (2*DATA_WIDTH)'(wgt);
        end
    end

    // Bias load takes priority; it never coincides with a product in the pixel schedule.
    always_comb begin
        acc_next = acc_reg;
        if (load_bias) begin
            acc_next = ACC_W'(bias) <<< FRAC_BITS;
        end else if (acc_en) begin
            acc_next = acc_reg + ACC_W'(prod);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    // Scale back to Q format, saturate, and optionally rectify.
    always_comb begin
        sat_val = q_shift_sat(64'(acc_reg), FRAC_BITS, DATA_WIDTH);
`ifdef CONV2D_RELU_EN
        result = (sat_val < 0) ? '0 : DATA_WIDTH'(sat_val);
`else
        result = DATA_WIDTH'(sat_val);
`endif
    end

endmodule

// File: rtl/conv2d_mac.sv
// conv2d_mac: sequential 2-D convolution engine, one output pixel at a time.
// Per pixel: BIAS (read bias), MAC (one tap per cycle), DRAIN (last product),
// WRITE (hold result until accepted). Optional macro CONV2D_RELU_EN (see mac_acc).
module conv2d_mac
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 7,
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 8,
    parameter int KERNEL       = 3,
    parameter int IMG_SIZE     = 28,
    parameter int STRIDE       = 1,
    parameter int PAD          = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         feat_rd_en,
    output logic [addr_w(IN_CHANNELS*IMG_SIZE*IMG_SIZE)-1:0] feat_addr,
    input  logic signed [DATA_WIDTH-1:0] feat_data,
    output logic                         wgt_rd_en,
    output logic [addr_w(OUT_CHANNELS*IN_CHANNELS*KERNEL*KERNEL)-1:0] wgt_addr,
    input  logic signed [DATA_WIDTH-1:0] wgt_data,
    output logic                         bias_rd_en,
    output logic [addr_w(OUT_CHANNELS)-1:0] bias_addr,
    input  logic signed [DATA_WIDTH-1:0] bias_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [addr_w(OUT_CHANNELS*((IMG_SIZE+2*PAD-KERNEL)/STRIDE+1)*((IMG_SIZE+2*PAD-KERNEL)/STRIDE+1))-1:0] out_addr,
    output logic signed [DATA_WIDTH-1:0] out_data
);

    localparam int OUT_SIZE = (IMG_SIZE + 2*PAD - KERNEL) / STRIDE + 1;
    localparam int N_TAPS   = IN_CHANNELS * KERNEL * KERNEL;
    localparam int FA_W     = addr_w(IN_CHANNELS * IMG_SIZE * IMG_SIZE);
    localparam int WA_W     = addr_w(OUT_CHANNELS * IN_CHANNELS * KERNEL * KERNEL);
    localparam int BA_W     = addr_w(OUT_CHANNELS);
    localparam int OA_W     = addr_w(OUT_CHANNELS * OUT_SIZE * OUT_SIZE);
    localparam int ACC_W    = 2*DATA_WIDTH + $clog2(N_TAPS) + 1;

    state_t state_reg;
    state_t state_next;
    int     oc_reg, row_reg, col_reg;
    int     ic_reg, ki_reg, kj_reg;
    logic   acc_en_reg;
    logic   pad_reg;
    int     in_r, in_c;
    logic   tap_in_img, first_tap, last_tap, last_pix;

    // Tap geometry: input coordinate of the current tap and loop-end flags.
    always_comb begin
        in_r       = row_reg * STRIDE + ki_reg - PAD;
        in_c       = col_reg * STRIDE + kj_reg - PAD;
        tap_in_img = (in_r >= 0) && (in_r < IMG_SIZE) && (in_c >= 0) && (in_c < IMG_SIZE);
        first_tap  = (ic_reg == 0) && (ki_reg == 0) && (kj_reg == 0);
        last_tap   = (ic_reg == IN_CHANNELS - 1) && (ki_reg == KERNEL - 1) && (kj_reg == KERNEL - 1);
        last_pix   = (oc_reg == OUT_CHANNELS - 1) && (row_reg == OUT_SIZE - 1) && (col_reg == OUT_SIZE - 1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = BIAS;
            BIAS:    state_next = MAC;
            MAC:     if (last_tap) state_next = DRAIN;
            DRAIN:   state_next = WRITE;
            WRITE:   if (out_ready) state_next = last_pix ? FINISH : BIAS;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Tap and pixel counters plus the one-cycle-delayed product qualifiers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            oc_reg     <= 0;
            row_reg    <= 0;
            col_reg    <= 0;
            ic_reg     <= 0;
            ki_reg     <= 0;
            kj_reg     <= 0;
            acc_en_reg <= 1'b0;
            pad_reg    <= 1'b0;
        end else begin
            acc_en_reg <= (state_reg == MAC);
            pad_reg    <= !tap_in_img;
            if (state_reg == IDLE && start) begin
                oc_reg  <= 0;
                row_reg <= 0;
                col_reg <= 0;
                ic_reg  <= 0;
                ki_reg  <= 0;
                kj_reg  <= 0;
            end
            if (state_reg == MAC) begin
                if (kj_reg == KERNEL - 1) begin
                    kj_reg <= 0;
                    if (ki_reg == KERNEL - 1) begin
                        ki_reg <= 0;
                        ic_reg <= (ic_reg == IN_CHANNELS - 1) ? 0 : ic_reg + 1;
                    end else begin
                        ki_reg <= ki_reg + 1;
                    end
                end else begin
                    kj_reg <= kj_reg + 1;
                end
            end
            if (state_reg == WRITE && out_ready) begin
                if (col_reg == OUT_SIZE - 1) begin
                    col_reg <= 0;
                    if (row_reg == OUT_SIZE - 1) begin
                        row_reg <= 0;
                        oc_reg  <= (oc_reg == OUT_CHANNELS - 1) ? 0 : oc_reg + 1;
                    end else begin
                        row_reg <= row_reg + 1;
                    end
                end else begin
                    col_reg <= col_reg + 1;
                end
            end
        end
    end

    // Status, memory-request and output-address decode.
    always_comb begin
        busy       = (state_reg != IDLE);
        done       = (state_reg == FINISH);
        out_valid  = (state_reg == WRITE);
        feat_rd_en = (state_reg == MAC) && tap_in_img;
        feat_addr  = feat_rd_en ? FA_W'(ic_reg * IMG_SIZE * IMG_SIZE + in_r * IMG_SIZE + in_c) : '0;
        wgt_rd_en  = (state_reg == MAC);
        wgt_addr   = wgt_rd_en ? WA_W'(((oc_reg * IN_CHANNELS + ic_reg) * KERNEL + ki_reg) * KERNEL + kj_reg) : '0;
        bias_rd_en = (state_reg == BIAS);
        bias_addr  = bias_rd_en ? BA_W'(oc_reg) : '0;
        out_addr   = OA_W'(oc_reg * OUT_SIZE * OUT_SIZE + row_reg * OUT_SIZE + col_reg);
    end

    mac_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_W      (ACC_W)
    ) u_mac_acc (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_bias ((state_reg == MAC) && first_tap),
        .bias      (bias_data),
        .acc_en    (acc_en_reg),
        .tap_zero  (pad_reg),
        .feat      (feat_data),
        .wgt       (wgt_data),
        .result    (out_data)
    );

endmodule

// File: tb/tb_conv2d_mac.sv
// tb_conv2d_mac: directed checks of conv2d_mac on a 28x28 map (identity, padding,
// saturation, reset, ReLU) and an 8x8 stride-2 map with output backpressure.
module tb_conv2d_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic reset_n;
    int   checks_total  = 0;
    int   checks_passed = 0;

`ifdef CONV2D_RELU_EN
    localparam int RELU_EXP = 0;
`else
    localparam int RELU_EXP = -256;
`endif

    // ---------------- DUT A: 28x28, IC=1, OC=1, stride 1, pad 1 ----------------
    logic               start_a, busy_a, done_a;
    logic               feat_rd_en_a, wgt_rd_en_a, bias_rd_en_a;
    logic [9:0]         feat_addr_a;
    logic [3:0]         wgt_addr_a;
    logic [0:0]         bias_addr_a;
    logic signed [15:0] feat_data_a = '0, wgt_data_a = '0, bias_data_a = '0;
    logic               out_valid_a, out_ready_a;
    logic [9:0]         out_addr_a;
    logic signed [15:0] out_data_a;
    logic signed [15:0] feat_mem_a [0:783];
    logic signed [15:0] wgt_mem_a  [0:8];
    logic signed [15:0] bias_mem_a [0:0];

    conv2d_mac #(
        .DATA_WIDTH(16), .FRAC_BITS(7), .IN_CHANNELS(1), .OUT_CHANNELS(1),
        .KERNEL(3), .IMG_SIZE(28), .STRIDE(1), .PAD(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .busy(busy_a), .done(done_a),
        .feat_rd_en(feat_rd_en_a), .feat_addr(feat_addr_a), .feat_data(feat_data_a),
        .wgt_rd_en(wgt_rd_en_a), .wgt_addr(wgt_addr_a), .wgt_data(wgt_data_a),
        .bias_rd_en(bias_rd_en_a), .bias_addr(bias_addr_a), .bias_data(bias_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_addr(out_addr_a), .out_data(out_data_a)
    );

    always @(posedge clk) begin
        if (feat_rd_en_a) feat_data_a <= feat_mem_a[feat_addr_a];
        if (wgt_rd_en_a)  wgt_data_a  <= wgt_mem_a[wgt_addr_a];
        if (bias_rd_en_a) bias_data_a <= bias_mem_a[bias_addr_a];
    end

    // ---------------- DUT B: 8x8, IC=1, OC=4, stride 2, pad 0 ----------------
    logic               start_b, busy_b, done_b;
    logic               feat_rd_en_b, wgt_rd_en_b, bias_rd_en_b;
    logic [5:0]         feat_addr_b, wgt_addr_b;
    logic [1:0]         bias_addr_b;
    logic signed [15:0] feat_data_b = '0, wgt_data_b = '0, bias_data_b = '0;
    logic               out_valid_b, out_ready_b;
    logic [5:0]         out_addr_b;
    logic signed [15:0] out_data_b;
    logic signed [15:0] feat_mem_b [0:63];
    logic signed [15:0] wgt_mem_b  [0:35];
    logic signed [15:0] bias_mem_b [0:3];

    conv2d_mac #(
        .DATA_WIDTH(16), .FRAC_BITS(7), .IN_CHANNELS(1), .OUT_CHANNELS(4),
        .KERNEL(3), .IMG_SIZE(8), .STRIDE(2), .PAD(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
        .feat_rd_en(feat_rd_en_b), .feat_addr(feat_addr_b), .feat_data(feat_data_b),
        .wgt_rd_en(wgt_rd_en_b), .wgt_addr(wgt_addr_b), .wgt_data(wgt_data_b),
        .bias_rd_en(bias_rd_en_b), .bias_addr(bias_addr_b), .bias_data(bias_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_addr(out_addr_b), .out_data(out_data_b)
    );

    always @(posedge clk) begin
        if (feat_rd_en_b) feat_data_b <= feat_mem_b[feat_addr_b];
        if (wgt_rd_en_b)  wgt_data_b  <= wgt_mem_b[wgt_addr_b];
        if (bias_rd_en_b) bias_data_b <= bias_mem_b[bias_addr_b];
    end

    // ---------------- capture state ----------------
    int   cap_a [0:783];
    int   hit_a [0:783];
    int   wr_a, done_cnt_a, first_addr_a, wr0_cyc_a, wr1_cyc_a, last_wr_cyc_a, done_cyc_a;
    logic timeout_a;
    int   cap_b [0:35];
    int   hit_b [0:35];
    int   wr_b, done_cnt_b, first_addr_b, last_addr_b;
    logic timeout_b;

    task automatic check_eq(input string tag, input longint observed, input longint expected);
        checks_total++;
        if (observed == expected) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Hand-derived expected output of DUT A for each 28x28 test image.
    function automatic int exp_a(input int kind, input int addr);
        int r, c, nr, nc;
        r  = addr / 28;
        c  = addr % 28;
        nr = 3 - ((r == 0) ? 1 : 0) - ((r == 27) ? 1 : 0);
        nc = 3 - ((c == 0) ? 1 : 0) - ((c == 27) ? 1 : 0);
        case (kind)
            0:       return addr;           // identity kernel
            1:       return nr * nc * 128;  // 1.0*1.0 per in-image tap
            2:       return 32767;
            3:       return -32768;
            default: return RELU_EXP;
        endcase
    endfunction

    // DUT B: channel oc has centre weight (oc+1)*1.0, image value = its address.
    function automatic int exp_b(input int addr);
        int oc, r, c;
        oc = addr / 9;
        r  = (addr % 9) / 3;
        c  = addr % 3;
        return (oc + 1) * ((2*r + 1) * 8 + 2*c + 1);
    endfunction

    task automatic run_map_a(input int abort_at);
        int tail;
        for (int i = 0; i < 784; i++) begin
            cap_a[i] = 0;
            hit_a[i] = 0;
        end
        wr_a = 0; done_cnt_a = 0; first_addr_a = -1; tail = 0; timeout_a = 1'b1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            if (out_valid_a && out_ready_a) begin
                if (wr_a == 0) begin
                    first_addr_a = int'(out_addr_a);
                    wr0_cyc_a    = cyc;
                end
                if (wr_a == 1) wr1_cyc_a = cyc;
                last_wr_cyc_a = cyc;
                if (out_addr_a < 10'd784) begin
                    cap_a[out_addr_a] = int'(out_data_a);
                    hit_a[out_addr_a] = hit_a[out_addr_a] + 1;
                end
                wr_a++;
            end
            if (done_a) begin
                done_cnt_a++;
                done_cyc_a = cyc;
            end
            if (abort_at >= 0 && wr_a == abort_at) begin
                timeout_a = 1'b0;
                break;
            end
            if (done_cnt_a > 0) tail++;
            if (tail > 16) begin
                timeout_a = 1'b0;
                break;
            end
        end
    endtask

    task automatic verify_map_a(input string tag, input int kind);
        int bad, hit_bad;
        bad = 0; hit_bad = 0;
        for (int i = 0; i < 784; i++) begin
            if (cap_a[i] != exp_a(kind, i)) bad++;
            if (hit_a[i] != 1) hit_bad++;
        end
        $display("map %s: writes=%0d done=%0d value_errs=%0d", tag, wr_a, done_cnt_a, bad);
        check_eq({tag, "_timeout"}, timeout_a, 0);
        check_eq({tag, "_value_errs"}, bad, 0);
        check_eq({tag, "_addr_hit_errs"}, hit_bad, 0);
        check_eq({tag, "_writes"}, wr_a, 784);
        check_eq({tag, "_first_addr"}, first_addr_a, 0);
        check_eq({tag, "_done_pulses"}, done_cnt_a, 1);
        check_eq({tag, "_done_delay"}, done_cyc_a - last_wr_cyc_a, 1);
    endtask

    task automatic run_map_b();
        int          tail;
        logic        stalled;
        logic [5:0]  held_addr;
        int          held_data;
        for (int i = 0; i < 36; i++) begin
            cap_b[i] = 0;
            hit_b[i] = 0;
        end
        wr_b = 0; done_cnt_b = 0; first_addr_b = -1; last_addr_b = -1;
        tail = 0; stalled = 1'b0; timeout_b = 1'b1;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (out_valid_b && wr_b == 4 && !stalled) begin
                stalled     = 1'b1;
                out_ready_b = 1'b0;
                held_addr   = out_addr_b;
                held_data   = int'(out_data_b);
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check_eq("bp_valid_held", out_valid_b, 1);
                    check_eq("bp_addr_held", out_addr_b, held_addr);
                    check_eq("bp_data_held", out_data_b, held_data);
                end
                out_ready_b = 1'b1;
            end
            if (out_valid_b && out_ready_b) begin
                if (wr_b == 0) first_addr_b = int'(out_addr_b);
                last_addr_b = int'(out_addr_b);
                if (out_addr_b < 6'd36) begin
                    cap_b[out_addr_b] = int'(out_data_b);
                    hit_b[out_addr_b] = hit_b[out_addr_b] + 1;
                end
                wr_b++;
            end
            if (done_b) done_cnt_b++;
            if (done_cnt_b > 0) tail++;
            if (tail > 16) begin
                timeout_b = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int bad, hit_bad, found;
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        out_ready_a = 1'b1; out_ready_b = 1'b1;
        for (int i = 0; i < 784; i++) feat_mem_a[i] = '0;
        for (int i = 0; i < 9; i++)   wgt_mem_a[i]  = '0;
        bias_mem_a[0] = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_out_valid", out_valid_a, 0);
        check_eq("rst_rd_en", {feat_rd_en_a, wgt_rd_en_a, bias_rd_en_a}, 0);
        check_eq("rst_addrs", {feat_addr_a, wgt_addr_a, bias_addr_a, out_addr_a}, 0);
        check_eq("rst_out_data", out_data_a, 0);
        check_eq("rst_busy_b", busy_b, 0);
        reset_n = 1'b1;

        // Identity kernel: output equals input pixel.
        for (int i = 0; i < 784; i++) feat_mem_a[i] = 16'(i);
        wgt_mem_a[4] = 16'sd128;
        run_map_a(-1);
        verify_map_a("ident", 0);
        check_eq("ident_px_latency", wr1_cyc_a - wr0_cyc_a, 12);
        check_eq("ident_px405", cap_a[405], 405);

        // Padding: constant 1.0 image and weights.
        for (int i = 0; i < 784; i++) feat_mem_a[i] = 16'sd128;
        for (int i = 0; i < 9; i++)   wgt_mem_a[i]  = 16'sd128;
        run_map_a(-1);
        verify_map_a("pad", 1);
        check_eq("pad_corner0", cap_a[0], 512);
        check_eq("pad_corner27", cap_a[27], 512);
        check_eq("pad_corner783", cap_a[783], 512);
        check_eq("pad_edge1", cap_a[1], 768);
        check_eq("pad_interior29", cap_a[29], 1152);

        // Positive saturation.
        for (int i = 0; i < 784; i++) feat_mem_a[i] = 16'sh7FFF;
        for (int i = 0; i < 9; i++)   wgt_mem_a[i]  = 16'sh7FFF;
        run_map_a(-1);
        verify_map_a("sat_pos", 2);
        check_eq("sat_pos_px0", cap_a[0], 32767);

        // Negative saturation.
        for (int i = 0; i < 784; i++) feat_mem_a[i] = 16'sh8000;
        run_map_a(-1);
        verify_map_a("sat_neg", 3);
        check_eq("sat_neg_px0", cap_a[0], -32768);

        // Stride 2, no padding, four output channels, with a 5-cycle stall.
        for (int i = 0; i < 64; i++) feat_mem_b[i] = 16'(i);
        for (int i = 0; i < 36; i++) wgt_mem_b[i]  = '0;
        for (int o = 0; o < 4; o++) begin
            wgt_mem_b[o*9 + 4] = 16'(128 * (o + 1));
            bias_mem_b[o]      = '0;
        end
        run_map_b();
        bad = 0; hit_bad = 0;
        for (int i = 0; i < 36; i++) begin
            if (cap_b[i] != exp_b(i)) bad++;
            if (hit_b[i] != 1) hit_bad++;
        end
        $display("map stride: writes=%0d done=%0d value_errs=%0d", wr_b, done_cnt_b, bad);
        check_eq("stride_timeout", timeout_b, 0);
        check_eq("stride_writes", wr_b, 36);
        check_eq("stride_value_errs", bad, 0);
        check_eq("stride_addr_hit_errs", hit_bad, 0);
        check_eq("stride_first_addr", first_addr_b, 0);
        check_eq("stride_last_addr", last_addr_b, 35);
        check_eq("stride_done_pulses", done_cnt_b, 1);
        check_eq("stride_px0", cap_b[0], 9);
        check_eq("stride_px13", cap_b[13], 54);
        check_eq("stride_px35", cap_b[35], 180);

        // Reset in the middle of a map, while pixel 10 is waiting to be written.
        run_map_a(10);
        check_eq("rst_mid_reached_px10", timeout_a, 0);
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid_a) begin
                found = 1;
                break;
            end
        end
        check_eq("rst_mid_px10_valid", found, 1);
        check_eq("rst_mid_px10_addr", out_addr_a, 10);
        out_ready_a = 1'b0;
        reset_n     = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_out_valid", out_valid_a, 0);
        check_eq("rst_mid_busy", busy_a, 0);
        check_eq("rst_mid_done", done_a, 0);
        reset_n     = 1'b1;
        out_ready_a = 1'b1;

        // ReLU: zero image, bias -2.0; also the restart after the reset above.
        for (int i = 0; i < 784; i++) feat_mem_a[i] = '0;
        bias_mem_a[0] = 16'shFF00;
        run_map_a(-1);
        verify_map_a("relu", 4);
        check_eq("relu_px0", cap_a[0], RELU_EXP);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
